// File: rtl/fdc_sector_buf.sv
// Sector buffer between the ESP fill path and TRS data-register reads, with FDC status.
// Latency: rd_data loads 1 cycle after rd_strobe; status/count/esp_req are registered next-state values.
// Backpressure: none; excess writes set OVERRUN, reads with no data set LOST.
module fdc_sector_buf #(
    parameter int REQ_PULSE = 50,
    parameter int DEPTH     = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_read,
    input  logic       cmd_abort,
    input  logic       wr_start,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    input  logic       wr_commit,
    input  logic       rd_strobe,
    output logic [7:0] rd_data,
    output logic [7:0] status,
    output logic       esp_req,
    output logic [8:0] count
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_READY} state_t;

    localparam logic [8:0]  FULL       = 9'(DEPTH);
    localparam logic [15:0] PULSE_LAST = 16'(REQ_PULSE - 1);

    state_t      state_q, state_nx;
    logic [7:0]  wr_ptr_q, wr_ptr_nx, rd_ptr_q, rd_ptr_nx;
    logic [8:0]  count_q, count_nx;
    logic        lost_q, lost_nx, ovr_q, ovr_nx, rnf_q, rnf_nx;
    logic [15:0] pulse_q, pulse_nx;
    logic        esp_req_nx;
    logic [7:0]  status_nx;
    logic        mem_we, rd_load;
    logic [7:0]  mem [DEPTH];

    assign count = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            lost_q   <= 1'b0;
            ovr_q    <= 1'b0;
            rnf_q    <= 1'b0;
            pulse_q  <= '0;
            esp_req  <= 1'b0;
            status   <= '0;
            rd_data  <= '0;
        end else begin
            state_q  <= state_nx;
            wr_ptr_q <= wr_ptr_nx;
            rd_ptr_q <= rd_ptr_nx;
            count_q  <= count_nx;
            lost_q   <= lost_nx;
            ovr_q    <= ovr_nx;
            rnf_q    <= rnf_nx;
            pulse_q  <= pulse_nx;
            esp_req  <= esp_req_nx;
            status   <= status_nx;
            if (rd_load) rd_data <= mem[rd_ptr_q];
        end
    end

    // Buffer contents survive reset; only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) mem[wr_ptr_q] <= wr_data;
    end

    always_comb begin
        state_nx  = state_q;
        wr_ptr_nx = wr_ptr_q;
        rd_ptr_nx = rd_ptr_q;
        count_nx  = count_q;
        lost_nx   = lost_q;
        ovr_nx    = ovr_q;
        rnf_nx    = rnf_q;
        mem_we    = 1'b0;
        rd_load   = 1'b0;
        if (cmd_abort) begin
            state_nx  = S_IDLE;
            wr_ptr_nx = '0;
            rd_ptr_nx = '0;
            count_nx  = '0;
        end else begin
            case (state_q)
                S_IDLE: if (cmd_read) begin
                    state_nx  = S_REQ;
                    lost_nx   = 1'b0;
                    ovr_nx    = 1'b0;
                    rnf_nx    = 1'b0;
                    wr_ptr_nx = '0;
                    rd_ptr_nx = '0;
                    count_nx  = '0;
                end
                S_REQ: if (wr_start) state_nx = S_FILL;
                S_FILL: begin
                    if (wr_valid) begin
                        if (count_q != FULL) begin
                            mem_we    = 1'b1;
                            wr_ptr_nx = wr_ptr_q + 8'd1;
                            count_nx  = count_q + 9'd1;
                        end else begin
                            ovr_nx = 1'b1;
                        end
                    end
                    // Commit sees the count including a byte stored on the same cycle.
                    if (wr_commit) begin
                        if (count_nx != 9'd0) begin
                            state_nx = S_READY;
                        end else begin
                            state_nx = S_IDLE;
                            rnf_nx   = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (rd_strobe) begin
                if (state_q == S_READY && count_q != 9'd0) begin
                    rd_load   = 1'b1;
                    rd_ptr_nx = rd_ptr_q + 8'd1;
                    count_nx  = count_q - 9'd1;
                    if (count_q == 9'd1) state_nx = S_IDLE;
                end else begin
                    lost_nx = 1'b1;
                end
            end
        end
    end

    always_comb begin
        esp_req_nx = 1'b0;
        pulse_nx   = pulse_q;
        if (state_nx == S_REQ) begin
            if (state_q != S_REQ) begin
                esp_req_nx = 1'b1;
                pulse_nx   = PULSE_LAST;
            end else if (esp_req && pulse_q != 16'd0) begin
                esp_req_nx = 1'b1;
                pulse_nx   = pulse_q - 16'd1;
            end
        end
        status_nx = {3'b000, rnf_nx, ovr_nx, lost_nx,
                     (state_nx == S_READY) && (count_nx != 9'd0),
                     state_nx != S_IDLE};
    end

endmodule

// File: tb/tb_fdc_sector_buf.sv
// Bench for fdc_sector_buf: vector table for the basic command flow, hand sequences for
// long fill/drain, abort and reset, with a byte queue as scoreboard for read data.
module tb_fdc_sector_buf;

    logic       clk = 1'b0;
    logic       rst, cmd_read, cmd_abort, wr_start, wr_valid, wr_commit, rd_strobe;
    logic [7:0] wr_data, rd_data, status;
    logic       esp_req;
    logic [8:0] count;

    always #5 clk = ~clk;

    fdc_sector_buf #(.REQ_PULSE(50), .DEPTH(256)) dut (
        .clk(clk), .rst(rst), .cmd_read(cmd_read), .cmd_abort(cmd_abort),
        .wr_start(wr_start), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_commit(wr_commit), .rd_strobe(rd_strobe), .rd_data(rd_data),
        .status(status), .esp_req(esp_req), .count(count)
    );

    typedef struct {
        logic       cr, ab, ws, wv;
        logic [7:0] wd;
        logic       wc, rs;
        logic [7:0] st;
        logic [8:0] cnt;
        logic       er;
        logic [7:0] rd;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] data_q[$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cr, input logic ab, input logic ws, input logic wv,
                         input logic [7:0] wd, input logic wc, input logic rs);
        @(negedge clk);
        cmd_read = cr; cmd_abort = ab; wr_start = ws; wr_valid = wv;
        wr_data = wd; wr_commit = wc; rd_strobe = rs;
        @(posedge clk);
        #1;
        cmd_read = 0; cmd_abort = 0; wr_start = 0; wr_valid = 0;
        wr_data = 0; wr_commit = 0; rd_strobe = 0;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 8'h00, 0, 0);
    endtask

    task automatic write_byte(input logic [7:0] b);
        data_q.push_back(b);
        drive(0, 0, 0, 1, b, 0, 0);
    endtask

    task automatic read_check(input string name);
        logic [7:0] exp;
        exp = data_q.pop_front();
        drive(0, 0, 0, 0, 8'h00, 0, 1);
        check(name, 16'(rd_data), 16'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        //            cr ab ws wv wd     wc rs  st     cnt    er rd
        tbl.push_back('{0, 0, 1, 0, 8'h00, 0, 0, 8'h01, 9'd0, 0, 8'h00});
        tbl.push_back('{0, 0, 0, 1, 8'hAA, 0, 0, 8'h01, 9'd1, 0, 8'h00});
        tbl.push_back('{0, 0, 0, 1, 8'h55, 0, 0, 8'h01, 9'd2, 0, 8'h00});
        tbl.push_back('{0, 0, 0, 1, 8'h01, 0, 0, 8'h01, 9'd3, 0, 8'h00});
        tbl.push_back('{0, 0, 0, 0, 8'h00, 1, 0, 8'h03, 9'd3, 0, 8'h00});
        tbl.push_back('{0, 0, 0, 0, 8'h00, 0, 1, 8'h03, 9'd2, 0, 8'hAA});
        tbl.push_back('{0, 0, 0, 0, 8'h00, 0, 1, 8'h03, 9'd1, 0, 8'h55});
        tbl.push_back('{0, 0, 0, 0, 8'h00, 0, 1, 8'h00, 9'd0, 0, 8'h01});
        tbl.push_back('{0, 0, 0, 0, 8'h00, 0, 1, 8'h04, 9'd0, 0, 8'h01});
        tbl.push_back('{0, 0, 0, 1, 8'h99, 0, 0, 8'h04, 9'd0, 0, 8'h01});
        tbl.push_back('{0, 0, 0, 0, 8'h00, 1, 0, 8'h04, 9'd0, 0, 8'h01});
        tbl.push_back('{1, 0, 0, 0, 8'h00, 0, 0, 8'h01, 9'd0, 1, 8'h01});
        tbl.push_back('{0, 0, 1, 0, 8'h00, 0, 0, 8'h01, 9'd0, 0, 8'h01});
        tbl.push_back('{0, 0, 0, 0, 8'h00, 1, 0, 8'h10, 9'd0, 0, 8'h01});
        tbl.push_back('{0, 0, 0, 0, 8'h00, 0, 1, 8'h14, 9'd0, 0, 8'h01});
        tbl.push_back('{0, 0, 1, 0, 8'h00, 0, 0, 8'h14, 9'd0, 0, 8'h01});
        tbl.push_back('{1, 0, 0, 0, 8'h00, 0, 0, 8'h01, 9'd0, 1, 8'h01});
        tbl.push_back('{0, 0, 1, 0, 8'h00, 0, 0, 8'h01, 9'd0, 0, 8'h01});
        tbl.push_back('{0, 0, 0, 1, 8'h77, 1, 0, 8'h03, 9'd1, 0, 8'h01});
        tbl.push_back('{0, 0, 0, 0, 8'h00, 0, 1, 8'h00, 9'd0, 0, 8'h77});
        tbl.push_back('{1, 0, 0, 0, 8'h00, 0, 0, 8'h01, 9'd0, 1, 8'h77});
        tbl.push_back('{0, 0, 1, 0, 8'h00, 0, 0, 8'h01, 9'd0, 0, 8'h77});
        tbl.push_back('{0, 0, 0, 1, 8'h12, 0, 0, 8'h01, 9'd1, 0, 8'h77});
        tbl.push_back('{1, 0, 0, 0, 8'h00, 0, 0, 8'h01, 9'd1, 0, 8'h77});
        tbl.push_back('{0, 0, 0, 1, 8'h34, 1, 0, 8'h03, 9'd2, 0, 8'h77});
        tbl.push_back('{0, 0, 0, 0, 8'h00, 0, 1, 8'h03, 9'd1, 0, 8'h12});
        tbl.push_back('{0, 0, 0, 0, 8'h00, 0, 1, 8'h00, 9'd0, 0, 8'h34});

        rst = 1; cmd_read = 0; cmd_abort = 0; wr_start = 0; wr_valid = 0;
        wr_data = 0; wr_commit = 0; rd_strobe = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rd_data", 16'(rd_data), 16'h00);
        check("reset status", 16'(status), 16'h00);
        check("reset esp_req", 16'(esp_req), 16'h0);
        check("reset count", 16'(count), 16'h0);
        @(negedge clk);
        rst = 0;

        // esp_req pulse width after cmd_read
        drive(1, 0, 0, 0, 8'h00, 0, 0);
        check("req first esp_req", 16'(esp_req), 16'h1);
        check("req status", 16'(status), 16'h01);
        for (int i = 1; i < 50; i++) begin
            idle();
            check($sformatf("req pulse cycle %0d", i), 16'(esp_req), 16'h1);
            check($sformatf("req status cycle %0d", i), 16'(status), 16'h01);
        end
        idle();
        check("req pulse end", 16'(esp_req), 16'h0);
        check("req status after pulse", 16'(status), 16'h01);

        foreach (tbl[i]) begin
            drive(tbl[i].cr, tbl[i].ab, tbl[i].ws, tbl[i].wv, tbl[i].wd, tbl[i].wc, tbl[i].rs);
            check($sformatf("vec%0d status", i), 16'(status), 16'(tbl[i].st));
            check($sformatf("vec%0d count", i), 16'(count), 16'(tbl[i].cnt));
            check($sformatf("vec%0d esp_req", i), 16'(esp_req), 16'(tbl[i].er));
            check($sformatf("vec%0d rd_data", i), 16'(rd_data), 16'(tbl[i].rd));
        end

        // Full sector plus one overflow byte, then drain through the pointer wrap
        drive(1, 0, 0, 0, 8'h00, 0, 0);
        drive(0, 0, 1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 256; i++) write_byte(8'(i));
        check("full count", 16'(count), 16'd256);
        check("full status", 16'(status), 16'h01);
        drive(0, 0, 0, 1, 8'hFF, 0, 0);
        check("overrun count", 16'(count), 16'd256);
        check("overrun status", 16'(status), 16'h09);
        drive(0, 0, 0, 0, 8'h00, 1, 0);
        check("full commit status", 16'(status), 16'h0B);
        for (int i = 0; i < 256; i++) read_check($sformatf("drain byte %0d", i));
        check("drain count", 16'(count), 16'd0);
        check("drain status", 16'(status), 16'h08);

        // Abort during the request pulse keeps flags
        drive(1, 0, 0, 0, 8'h00, 0, 0);
        idle();
        drive(0, 0, 0, 0, 8'h00, 0, 1);
        check("lost in req status", 16'(status), 16'h05);
        check("lost in req esp_req", 16'(esp_req), 16'h1);
        drive(0, 1, 0, 0, 8'h00, 0, 0);
        check("abort req esp_req", 16'(esp_req), 16'h0);
        check("abort req status", 16'(status), 16'h04);
        check("abort req count", 16'(count), 16'd0);
        drive(1, 0, 0, 0, 8'h00, 0, 0);
        check("cmd_read clears flags", 16'(status), 16'h01);

        // Abort mid-drain with five bytes left
        drive(0, 0, 1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 7; i++) write_byte(8'hA0 + 8'(i));
        drive(0, 0, 0, 0, 8'h00, 1, 0);
        check("drain7 status", 16'(status), 16'h03);
        read_check("abort drain byte 0");
        read_check("abort drain byte 1");
        check("pre-abort count", 16'(count), 16'd5);
        drive(0, 1, 0, 0, 8'h00, 0, 0);
        data_q.delete();
        check("abort drain count", 16'(count), 16'd0);
        check("abort drain status", 16'(status), 16'h00);
        check("abort drain rd_data", 16'(rd_data), 16'hA1);

        // Reset in the middle of a fill
        drive(1, 0, 0, 0, 8'h00, 0, 0);
        drive(0, 0, 1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 10; i++) write_byte(8'h30 + 8'(i));
        data_q.delete();
        check("pre-reset count", 16'(count), 16'd10);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        check("midfill reset rd_data", 16'(rd_data), 16'h00);
        check("midfill reset status", 16'(status), 16'h00);
        check("midfill reset esp_req", 16'(esp_req), 16'h0);
        check("midfill reset count", 16'(count), 16'd0);
        drive(0, 0, 0, 1, 8'h5A, 0, 0);
        check("post-reset write count", 16'(count), 16'd0);
        check("post-reset write status", 16'(status), 16'h00);
        drive(0, 0, 1, 0, 8'h00, 0, 0);
        drive(0, 0, 0, 1, 8'h5B, 0, 0);
        check("wr_start in idle ignored", 16'(count), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
